// File: rtl/axis_uart_pkg.sv
// Shared definitions for the AXI-Stream UART transceiver: FSM state encodings,
// bit-timing / frame-count derivation and the odd-parity helper.
package axis_uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    function automatic int calc_cpb(input int clock, input int baud_rate);
        return clock / baud_rate;
    endfunction

    function automatic int calc_nf(input int axi_data_width, input int data_bits);
        return axi_data_width / data_bits;
    endfunction

    // Odd parity: the parity bit is the complement of the running XOR of the data bits.
    function automatic logic odd_parity_bit(input logic xor_acc);
        return ~xor_acc;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle (data, valid, ready) with master and slave views.
interface axis_if #(
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_DATA_WIDTH-1:0] tdata;
    logic                      tvalid;
    logic                      tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx.sv
// UART receiver: synchronises uart_rx, samples each bit at its centre and
// assembles NF frames into one AXIS word held until the sink accepts it.
module axis_uart_rx
    import axis_uart_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CLOCK          = 20_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      srst,
    input  logic                      rx,
    output logic [AXI_DATA_WIDTH-1:0] tdata,
    output logic                      tvalid,
    input  logic                      tready,
    output logic                      done,
    output logic [1:0]                err
);
    localparam int CPB   = calc_cpb(CLOCK, BAUD_RATE);
    localparam int NF    = calc_nf(AXI_DATA_WIDTH, DATA_BITS);
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int FRM_W = $clog2(NF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CPB / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(NF - 1);
    localparam logic             STOP_LAST  = (STOP_BITS == 32'sd2);
    localparam bit               HAS_PARITY = (PARITY_BITS != 32'sd0);

    logic                      meta_r, sync_r, prev_r;
    rx_state_t                 state_r, state_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s;
    logic [BIT_W-1:0]          bit_r, bit_s;
    logic [FRM_W-1:0]          frame_r, frame_s;
    logic                      stop_r, stop_s;
    logic [AXI_DATA_WIDTH-1:0] word_r, word_s;
    logic                      par_r, par_s;
    logic                      perr_r, perr_s;
    logic                      ferr_r, ferr_s;
    logic [AXI_DATA_WIDTH-1:0] tdata_r, tdata_s;
    logic                      tvalid_r, tvalid_s;
    logic                      done_r, done_s;
    logic [1:0]                err_r, err_s;
    logic                      bit_end_s;
    logic                      ferr_acc_s;

    assign tdata  = tdata_r;
    assign tvalid = tvalid_r;
    assign done   = done_r;
    assign err    = err_r;

    // Two-flop synchroniser, edge-detect history and FSM/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r   <= 1'b1;
            sync_r   <= 1'b1;
            prev_r   <= 1'b1;
            state_r  <= RX_IDLE;
            cnt_r    <= '0;
            bit_r    <= '0;
            frame_r  <= '0;
            stop_r   <= 1'b0;
            word_r   <= '0;
            par_r    <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            tdata_r  <= '0;
            tvalid_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 2'b00;
        end else if (srst) begin
            meta_r   <= 1'b1;
            sync_r   <= 1'b1;
            prev_r   <= 1'b1;
            state_r  <= RX_IDLE;
            cnt_r    <= '0;
            bit_r    <= '0;
            frame_r  <= '0;
            stop_r   <= 1'b0;
            word_r   <= '0;
            par_r    <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            tdata_r  <= '0;
            tvalid_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 2'b00;
        end else begin
            meta_r   <= rx;
            sync_r   <= meta_r;
            prev_r   <= sync_r;
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            bit_r    <= bit_s;
            frame_r  <= frame_s;
            stop_r   <= stop_s;
            word_r   <= word_s;
            par_r    <= par_s;
            perr_r   <= perr_s;
            ferr_r   <= ferr_s;
            tdata_r  <= tdata_s;
            tvalid_r <= tvalid_s;
            done_r   <= done_s;
            err_r    <= err_s;
        end
    end

    // Next-state logic; data bits shift in at the MSB so frame 0 ends up in the low chunk.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + 1'b1;
        bit_s      = bit_r;
        frame_s    = frame_r;
        stop_s     = stop_r;
        word_s     = word_r;
        par_s      = par_r;
        perr_s     = perr_r;
        ferr_s     = ferr_r;
        tdata_s    = tdata_r;
        tvalid_s   = tvalid_r & ~tready;
        done_s     = 1'b0;
        err_s      = 2'b00;
        bit_end_s  = (cnt_r == CNT_LAST);
        ferr_acc_s = ferr_r | ~sync_r;
        case (state_r)
            RX_IDLE: begin
                cnt_s = '0;
                if (prev_r && !sync_r) begin
                    state_s = RX_START;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = '0;
                    if (sync_r) begin
                        state_s = RX_IDLE;
                    end else begin
                        bit_s   = '0;
                        stop_s  = 1'b0;
                        par_s   = 1'b0;
                        perr_s  = 1'b0;
                        ferr_s  = 1'b0;
                        state_s = RX_DATA;
                    end
                end else begin
                    state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (bit_end_s) begin
                    cnt_s  = '0;
                    word_s = {sync_r, word_r[AXI_DATA_WIDTH-1:1]};
                    par_s  = par_r ^ sync_r;
                    if (bit_r == BIT_LAST) begin
                        state_s = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_s = bit_r + 1'b1;
                    end
                end else begin
                    state_s = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (bit_end_s) begin
                    cnt_s   = '0;
                    perr_s  = (sync_r != odd_parity_bit(par_r));
                    state_s = RX_STOP;
                end else begin
                    state_s = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (bit_end_s) begin
                    cnt_s = '0;
                    if (stop_r == STOP_LAST) begin
                        err_s   = {ferr_acc_s, perr_r};
                        state_s = RX_IDLE;
                        if (frame_r == FRM_LAST) begin
                            frame_s = '0;
                            // A word finishing while the previous one is still pending is dropped.
                            if (!tvalid_r) begin
                                tdata_s  = word_r;
                                tvalid_s = 1'b1;
                                done_s   = 1'b1;
                            end else begin
                                tdata_s  = tdata_r;
                            end
                        end else begin
                            frame_s = frame_r + 1'b1;
                        end
                    end else begin
                        stop_s = stop_r + 1'b1;
                        ferr_s = ferr_acc_s;
                    end
                end else begin
                    state_s = RX_STOP;
                end
            end
            default: begin
                state_s = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/axis_uart_tx.sv
// UART transmitter: latches one AXIS word and serialises it as NF back-to-back
// frames, least-significant chunk first; uart_tx comes straight from a flop.
module axis_uart_tx
    import axis_uart_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CLOCK          = 20_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      srst,
    input  logic [AXI_DATA_WIDTH-1:0] tdata,
    input  logic                      tvalid,
    output logic                      tready,
    output logic                      tx,
    output logic                      done
);
    localparam int CPB   = calc_cpb(CLOCK, BAUD_RATE);
    localparam int NF    = calc_nf(AXI_DATA_WIDTH, DATA_BITS);
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int FRM_W = $clog2(NF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(NF - 1);
    localparam logic             STOP_LAST  = (STOP_BITS == 32'sd2);
    localparam bit               HAS_PARITY = (PARITY_BITS != 32'sd0);

    tx_state_t                 state_r, state_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s;
    logic [BIT_W-1:0]          bit_r, bit_s;
    logic [FRM_W-1:0]          frame_r, frame_s;
    logic                      stop_r, stop_s;
    logic [AXI_DATA_WIDTH-1:0] shift_r, shift_s;
    logic                      par_r, par_s;
    logic                      tx_r, tx_s;
    logic                      tready_r, tready_s;
    logic                      done_r, done_s;
    logic                      bit_end_s;

    assign tready = tready_r;
    assign tx     = tx_r;
    assign done   = done_r;

    // State and output registers; the word is consumed from shift_r bit 0 upward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= TX_IDLE;
            cnt_r    <= '0;
            bit_r    <= '0;
            frame_r  <= '0;
            stop_r   <= 1'b0;
            shift_r  <= '0;
            par_r    <= 1'b0;
            tx_r     <= 1'b1;
            tready_r <= 1'b0;
            done_r   <= 1'b0;
        end else if (srst) begin
            state_r  <= TX_IDLE;
            cnt_r    <= '0;
            bit_r    <= '0;
            frame_r  <= '0;
            stop_r   <= 1'b0;
            shift_r  <= '0;
            par_r    <= 1'b0;
            tx_r     <= 1'b1;
            tready_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            bit_r    <= bit_s;
            frame_r  <= frame_s;
            stop_r   <= stop_s;
            shift_r  <= shift_s;
            par_r    <= par_s;
            tx_r     <= tx_s;
            tready_r <= tready_s;
            done_r   <= done_s;
        end
    end

    // Next-state logic; tx_s is the level of the bit that starts at the next edge.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + 1'b1;
        bit_s     = bit_r;
        frame_s   = frame_r;
        stop_s    = stop_r;
        shift_s   = shift_r;
        par_s     = par_r;
        tx_s      = tx_r;
        tready_s  = tready_r;
        done_s    = 1'b0;
        bit_end_s = (cnt_r == CNT_LAST);
        case (state_r)
            TX_IDLE: begin
                cnt_s    = '0;
                tx_s     = 1'b1;
                tready_s = 1'b1;
                if (tready_r && tvalid) begin
                    shift_s  = tdata;
                    frame_s  = '0;
                    tx_s     = 1'b0;
                    tready_s = 1'b0;
                    state_s  = TX_START;
                end else begin
                    state_s  = TX_IDLE;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    cnt_s   = '0;
                    bit_s   = '0;
                    par_s   = 1'b0;
                    tx_s    = shift_r[0];
                    state_s = TX_DATA;
                end else begin
                    state_s = TX_START;
                end
            end
            TX_DATA: begin
                if (bit_end_s) begin
                    cnt_s   = '0;
                    par_s   = par_r ^ shift_r[0];
                    shift_s = shift_r >> 1;
                    if (bit_r == BIT_LAST) begin
                        if (HAS_PARITY) begin
                            tx_s    = odd_parity_bit(par_s);
                            state_s = TX_PARITY;
                        end else begin
                            tx_s    = 1'b1;
                            stop_s  = 1'b0;
                            state_s = TX_STOP;
                        end
                    end else begin
                        bit_s = bit_r + 1'b1;
                        tx_s  = shift_s[0];
                    end
                end else begin
                    state_s = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (bit_end_s) begin
                    cnt_s   = '0;
                    tx_s    = 1'b1;
                    stop_s  = 1'b0;
                    state_s = TX_STOP;
                end else begin
                    state_s = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (bit_end_s) begin
                    cnt_s = '0;
                    if (stop_r == STOP_LAST) begin
                        if (frame_r == FRM_LAST) begin
                            done_s   = 1'b1;
                            tready_s = 1'b1;
                            tx_s     = 1'b1;
                            state_s  = TX_IDLE;
                        end else begin
                            frame_s  = frame_r + 1'b1;
                            tx_s     = 1'b0;
                            state_s  = TX_START;
                        end
                    end else begin
                        stop_s = stop_r + 1'b1;
                    end
                end else begin
                    state_s = TX_STOP;
                end
            end
            default: begin
                state_s  = TX_IDLE;
                tx_s     = 1'b1;
                tready_s = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/axis_uart_transceiver.sv
// AXI-Stream to UART bridge: independent receiver and transmitter sharing only
// the clock and reset.
module axis_uart_transceiver #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CLOCK          = 20_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_BITS    = 1
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       rx_done,
    output logic [1:0] rx_error,
    output logic       tx_done,
    axis_if.master     m_axis,
    axis_if.slave      s_axis
);

    axis_uart_rx #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .CLOCK          (CLOCK),
        .BAUD_RATE      (BAUD_RATE),
        .DATA_BITS      (DATA_BITS),
        .STOP_BITS      (STOP_BITS),
        .PARITY_BITS    (PARITY_BITS)
    ) u_rx (
        .clk    (aclk),
        .rst_n  (aresetn),
        .srst   (1'b0),
        .rx     (uart_rx),
        .tdata  (m_axis.tdata),
        .tvalid (m_axis.tvalid),
        .tready (m_axis.tready),
        .done   (rx_done),
        .err    (rx_error)
    );

    axis_uart_tx #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .CLOCK          (CLOCK),
        .BAUD_RATE      (BAUD_RATE),
        .DATA_BITS      (DATA_BITS),
        .STOP_BITS      (STOP_BITS),
        .PARITY_BITS    (PARITY_BITS)
    ) u_tx (
        .clk    (aclk),
        .rst_n  (aresetn),
        .srst   (1'b0),
        .tdata  (s_axis.tdata),
        .tvalid (s_axis.tvalid),
        .tready (s_axis.tready),
        .tx     (uart_tx),
        .done   (tx_done)
    );

endmodule

// File: tb/tb_axis_uart_transceiver.sv
// Self-checking bench: random words through both directions against a
// frame-level model of the UART line format.
module tb_axis_uart_transceiver;

    localparam int CPB   = 20_000_000 / 115200;
    localparam int NF    = 4;
    localparam int BPF   = 11;
    localparam int NBITS = NF * BPF;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       uart_rx;
    logic       uart_tx;
    logic       rx_done;
    logic [1:0] rx_error;
    logic       tx_done;

    axis_if #(.AXI_DATA_WIDTH(32)) m_if ();
    axis_if #(.AXI_DATA_WIDTH(32)) s_if ();

    int vec_cnt     = 0;
    int miscmp_cnt  = 0;
    int tx_done_cnt = 0;

    logic [31:0] rx_exp_q[$];
    logic [1:0]  rx_err_exp_q[$];
    logic [1:0]  rx_err_obs_q[$];

    axis_uart_transceiver #(
        .AXI_DATA_WIDTH (32),
        .CLOCK          (20_000_000),
        .BAUD_RATE      (115200),
        .DATA_BITS      (8),
        .STOP_BITS      (1),
        .PARITY_BITS    (1)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .rx_done  (rx_done),
        .rx_error (rx_error),
        .tx_done  (tx_done),
        .m_axis   (m_if),
        .s_axis   (s_if)
    );

    always #25 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: every delivered word must be the next one the model expects.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (tx_done === 1'b1) tx_done_cnt++;
            if (rx_error !== 2'b00) rx_err_obs_q.push_back(rx_error);
            if (rx_done === 1'b1) begin
                check_val("rx_word_expected", 32'(rx_exp_q.size() > 0), 32'd1);
                if (rx_exp_q.size() > 0) begin
                    check_val("rx_tdata", m_if.tdata, rx_exp_q.pop_front());
                    check_val("rx_tvalid", 32'(m_if.tvalid), 32'd1);
                end
            end
        end
    end

    initial begin
        #6_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (CPB) @(negedge aclk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop, input int gap);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit((~^d) ^ bad_par);
        drive_bit(~bad_stop);
        uart_rx = 1'b1;
        repeat (gap) @(negedge aclk);
    endtask

    task automatic rx_word(input logic [31:0] w, input logic [3:0] bp, input logic [3:0] bs, input logic expect_load);
        if (expect_load) rx_exp_q.push_back(w);
        for (int k = 0; k < NF; k++) begin
            drive_frame(w[8*k +: 8], bp[k], bs[k], bs[k] ? int'($urandom_range(20, 3)) : int'($urandom_range(20, 0)));
            if (bp[k] || bs[k]) rx_err_exp_q.push_back({bs[k], bp[k]});
        end
        repeat (4) @(negedge aclk);
        check_val("rx_word_delivered", 32'(rx_exp_q.size()), 32'd0);
        check_val("rx_err_count", 32'(rx_err_obs_q.size()), 32'(rx_err_exp_q.size()));
        for (int i = 0; i < rx_err_exp_q.size() && i < rx_err_obs_q.size(); i++)
            check_val("rx_err_kind", 32'(rx_err_obs_q[i]), 32'(rx_err_exp_q[i]));
        rx_exp_q.delete();
        rx_err_exp_q.delete();
        rx_err_obs_q.delete();
    endtask

    task automatic send_tx(input logic [31:0] w);
        logic [NBITS-1:0] exp_v, first_v, last_v;
        logic [7:0]       got_d;
        int               n;
        n = 0;
        for (int k = 0; k < NF; k++) begin
            exp_v[k*BPF]      = 1'b0;
            for (int i = 0; i < 8; i++) exp_v[k*BPF + 1 + i] = w[8*k + i];
            exp_v[k*BPF + 9]  = ~^w[8*k +: 8];
            exp_v[k*BPF + 10] = 1'b1;
        end
        @(negedge aclk);
        while (s_if.tready !== 1'b1 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check_val("tx_tready_idle", 32'(s_if.tready), 32'd1);
        s_if.tdata  = w;
        s_if.tvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        s_if.tvalid = 1'b0;
        check_val("tx_tready_busy", 32'(s_if.tready), 32'd0);
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge aclk);
                if (c == 0) first_v[b] = uart_tx;
                if (c == CPB - 1) last_v[b] = uart_tx;
            end
        end
        for (int k = 0; k < NF; k++) begin
            for (int i = 0; i < 8; i++) got_d[i] = first_v[k*BPF + 1 + i];
            check_val("tx_frame_data", 32'(got_d), 32'(w[8*k +: 8]));
            check_val("tx_parity", 32'(first_v[k*BPF + 9]), 32'(~^w[8*k +: 8]));
            check_val("tx_start_stop", 32'({first_v[k*BPF], first_v[k*BPF + 10]}), 32'd1);
        end
        check_val("tx_bit_hold", 32'($countones(last_v ^ exp_v)), 32'd0);
        check_val("tx_first_vs_model", 32'($countones(first_v ^ exp_v)), 32'd0);
        @(negedge aclk);
        check_val("tx_done_pulse", 32'(tx_done), 32'd1);
        check_val("tx_tready_back", 32'(s_if.tready), 32'd1);
        check_val("tx_line_idle", 32'(uart_tx), 32'd1);
        @(negedge aclk);
        check_val("tx_done_one_cycle", 32'(tx_done), 32'd0);
    endtask

    initial begin
        logic [31:0] bp_word;
        bit          stable;
        aresetn     = 1'b0;
        uart_rx     = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'd0;
        m_if.tready = 1'b1;

        #100;
        check_val("reset_uart_tx", 32'(uart_tx), 32'd1);
        check_val("reset_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check_val("reset_m_tdata", m_if.tdata, 32'd0);
        check_val("reset_s_tready", 32'(s_if.tready), 32'd0);
        check_val("reset_pulses", 32'({rx_done, tx_done, rx_error}), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        check_val("release_tready_low", 32'(s_if.tready), 32'd0);
        @(posedge aclk);
        #1;
        check_val("release_tready_high", 32'(s_if.tready), 32'd1);

        // Abort both directions mid-frame with reset.
        @(negedge aclk);
        s_if.tdata  = $urandom;
        s_if.tvalid = 1'b1;
        @(negedge aclk);
        s_if.tvalid = 1'b0;
        drive_frame(8'($urandom), 1'b0, 1'b0, 10);
        check_val("abort_tx_busy", 32'(uart_tx), 32'd0);
        aresetn = 1'b0;
        #1;
        check_val("abort_uart_tx", 32'(uart_tx), 32'd1);
        check_val("abort_tready", 32'(s_if.tready), 32'd0);
        check_val("abort_tvalid", 32'(m_if.tvalid), 32'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        rx_err_obs_q.delete();

        // Both directions running concurrently.
        tx_done_cnt = 0;
        fork
            begin
                send_tx(32'hA5C30F12);
                send_tx($urandom);
                send_tx($urandom);
            end
            begin
                rx_word(32'h44332211, 4'h0, 4'h0, 1'b1);
                rx_word({24'($urandom), 8'h11}, 4'b0001, 4'b0000, 1'b1);
                rx_word($urandom, 4'b0000, 4'b0100, 1'b1);
                rx_word($urandom, 4'($urandom), 4'($urandom), 1'b1);
            end
        join
        check_val("tx_done_count", 32'(tx_done_cnt), 32'd3);

        // Short low glitch must be ignored; a real word afterwards must still decode.
        uart_rx = 1'b0;
        repeat (50) @(negedge aclk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge aclk);
        check_val("glitch_no_error", 32'(rx_err_obs_q.size()), 32'd0);
        check_val("glitch_no_word", 32'(m_if.tvalid), 32'd0);
        rx_word($urandom, 4'h0, 4'h0, 1'b1);

        // Backpressure: pending word held, second word dropped, one pulse consumes one word.
        m_if.tready = 1'b0;
        bp_word = $urandom;
        rx_word(bp_word, 4'h0, 4'h0, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge aclk);
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== bp_word) stable = 1'b0;
        end
        check_val("bp_hold_stable", 32'(stable), 32'd1);
        rx_word(~bp_word, 4'h0, 4'h0, 1'b0);
        check_val("bp_pending_kept", m_if.tdata, bp_word);
        check_val("bp_pending_valid", 32'(m_if.tvalid), 32'd1);
        m_if.tready = 1'b1;
        @(negedge aclk);
        m_if.tready = 1'b0;
        check_val("bp_valid_cleared", 32'(m_if.tvalid), 32'd0);
        repeat (20) @(negedge aclk);
        check_val("bp_one_consumed", 32'(m_if.tvalid), 32'd0);
        m_if.tready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
